ila_readout: RTL and testbench

Reads the contents of the ILA sample memory after a capture and streams them to the host link as bytes. It drives the sample memory's read port, starting at the oldest sample in the ring buffer and wrapping modulo depth. Each word is serialised LSB byte first over a valid/ready byte interface that feeds the UART/SPI transport. It runs entirely in the read clock domain; its `clk` is the memory's read clock.

---
 rtl/ila_pkg.sv | 19 +
 rtl/ila_byte_serializer.sv | 47 ++++
 rtl/ila_readout.sv | 117 +++++++++++
 tb/tb_ila_readout.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ila_pkg.sv
// Shared types for the ILA sample-memory readout path.
// State encoding and word/byte sizing helper.
package ila_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    LOAD,
    SEND,
    SUM,
    FIN
  } ila_rd_state_t;

  function automatic int bytes_per_word(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/ila_byte_serializer.sv
// Splits one sample word into bytes, LSB first, over a valid/ready link.
// The final byte carries the top bits, zero-padded.
module ila_byte_serializer
  import ila_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  load,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  last
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [BPW*8-1:0] sr;
  logic [IW-1:0]    idx;
  logic             valid;
  logic             xfer;

  assign xfer     = valid && tx_ready;
  assign last     = xfer && (idx == IW'(BPW - 1));
  assign tx_data  = sr[7:0];
  assign tx_valid = valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      sr    <= (BPW*8)'(word);
      idx   <= '0;
      valid <= 1'b1;
    end else if (xfer) begin
      sr  <= sr >> 8;
      idx <= idx + 1'b1;
      if (last) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ila_readout.sv
// Streams captured ILA samples from the ring buffer to the host as bytes.
// Define ILA_READOUT_CHECKSUM_EN to append an XOR checksum byte.
module ila_readout
  import ila_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   sample_cnt,
  output logic [ADDR_WIDTH-1:0] addr_read,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

`ifdef ILA_READOUT_CHECKSUM_EN
  localparam ila_rd_state_t END_ST = SUM;
`else
  localparam ila_rd_state_t END_ST = FIN;
`endif

  ila_rd_state_t       state, state_n;
  logic [ADDR_WIDTH:0] remain;
  logic [ADDR_WIDTH:0] cnt_clamp;
  logic                load;
  logic                last;
  logic                ser_valid;
  logic [7:0]          ser_data;

  assign cnt_clamp = (sample_cnt > DEPTH) ? DEPTH : sample_cnt;

  ila_byte_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .word    (rd_data),
    .load    (load),
    .tx_data (ser_data),
    .tx_valid(ser_valid),
    .tx_ready(tx_ready),
    .last    (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = (cnt_clamp == '0) ? END_ST : RD;
      RD:   state_n = WAIT;
      WAIT: state_n = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        if (last)
          state_n = (remain == (ADDR_WIDTH+1)'(1)) ? END_ST : RD;
      end
      SUM:  if (tx_ready) state_n = FIN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // addr_read doubles as the ring-buffer address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_read <= '0;
      remain    <= '0;
    end else if (state == IDLE && start) begin
      addr_read <= start_addr;
      remain    <= cnt_clamp;
    end else if (state == SEND && last) begin
      addr_read <= addr_read + 1'b1;
      remain    <= remain - 1'b1;
    end
  end

`ifdef ILA_READOUT_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (state == SEND && ser_valid && tx_ready) begin
      csum <= csum ^ ser_data;
    end
  end

  assign tx_valid = ser_valid || (state == SUM);
  assign tx_data  = (state == SUM) ? csum : ser_data;
`else
  assign tx_valid = ser_valid;
  assign tx_data  = ser_data;
`endif

  assign busy = (state != IDLE) && (state != FIN);
  assign done = (state == FIN);

endmodule

// File: tb/tb_ila_readout.sv
// Scoreboard bench for ila_readout: randomized readouts against a byte-stream model.
// Honours ILA_READOUT_CHECKSUM_EN when the design is built with it.
module tb_ila_readout;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int BPW   = 4;
`ifdef ILA_READOUT_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  typedef struct {
    logic [7:0]    b;
    bit            first;
    logic [AW-1:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   sample_cnt = '0;
  logic          tx_ready = 1'b1;
  logic [AW-1:0] addr_read;
  logic [DW-1:0] rd_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];
  exp_t          q[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail = 0;
  int            done_cnt = 0;
  int            ready_mode = 0;
  logic          pv = 1'b0;
  logic [7:0]    pd = '0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[addr_read];

  ila_readout #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .sample_cnt(sample_cnt),
    .addr_read (addr_read),
    .rd_data   (rd_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: the byte stream a readout must produce, from memory contents
  function automatic int push_exp(input int sa, input int cnt);
    int         n;
    logic [7:0] x;
    exp_t       e;
    logic [DW-1:0] w;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    x = '0;
    for (int i = 0; i < n; i++) begin
      w = mem[(sa + i) % DEPTH];
      for (int b = 0; b < BPW; b++) begin
        e.b     = w[8*b +: 8];
        e.first = (b == 0);
        e.addr  = AW'((sa + i) % DEPTH);
        x       = x ^ e.b;
        q.push_back(e);
      end
    end
    if (CK != 0) begin
      e.b     = x;
      e.first = 1'b0;
      e.addr  = '0;
      q.push_back(e);
    end
    return n;
  endfunction

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) tx_ready = 1'b1;
    else if (ready_mode == 1) tx_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every transfer, checks stall stability
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, pd);
      end
      if (tx_valid && tx_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_byte: got %0h expected none", tx_data);
        end else begin
          mon_e = q.pop_front();
          chk("byte", tx_data, mon_e.b);
          if (mon_e.first) chk("word_addr", addr_read, mon_e.addr);
        end
      end
      if (done) done_cnt++;
      pv = tx_valid && !tx_ready;
      pd = tx_data;
    end
  end

  task automatic run(input int sa, input int cnt, input int mode,
                     input bit timing, input int ign_at);
    int n, k, first;
    bit got;
    @(posedge clk);
    #1;
    ready_mode = mode;
    if (mode == 2) tx_ready = 1'b1;
    n = push_exp(sa, cnt);
    start      = 1'b1;
    start_addr = AW'(sa);
    sample_cnt = (AW+1)'(cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
    k     = 0;
    first = -1;
    got   = 1'b0;
    while (k < 3000) begin
      @(negedge clk);
      if (k == 0) chk("busy_after_start", busy, (n > 0 || CK != 0) ? 1 : 0);
      if (tx_valid && first < 0) first = k;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      k++;
      if (mode == 2) tx_ready = !(k >= 5 && k < 10);
      start = (k == ign_at);
      if (start) begin
        start_addr = AW'(sa + 7);
        sample_cnt = 1;
      end
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    chk("busy_at_done", busy, 0);
    if (timing) begin
      chk("first_valid", first, (n > 0) ? 3 : ((CK != 0) ? 0 : -1));
      chk("done_cycle", k, n * (BPW + 3) + CK);
    end
    @(negedge clk);
    chk("done_width", done, 0);
    chk("queue_drained", q.size(), 0);
    ready_mode = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    bit seen;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[5] = 32'hAABBCCDD;
    mem[8] = 32'h01020304;
    mem[9] = 32'h10203040;

    #12;
    chk("rst_addr_read", addr_read, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    run(5, 1, 0, 1, -1);
    run(14, 4, 0, 1, -1);
    run(3, 2, 2, 0, -1);
    run(11, 0, 0, 1, -1);
    run(7, DEPTH + 3, 0, 1, -1);
    run(0, DEPTH, 1, 0, -1);
    run(3, 3, 0, 1, 5);
    run(8, 2, 0, 1, -1);

    // Abort in the middle of a word
    @(posedge clk);
    #1;
    n          = push_exp(2, 3);
    start      = 1'b1;
    start_addr = 2;
    sample_cnt = 3;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reach_send", seen, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr_read", addr_read, 0);
    d0 = done_cnt;
    q.delete();
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    chk("no_done_after_rst", done_cnt, d0);
    run(9, 2, 0, 1, -1);

    for (int i = 0; i < 20; i++) begin
      run($urandom_range(0, DEPTH - 1), $urandom_range(0, 20),
          i % 2, (i % 2) == 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
